// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, buffer entry
// layout and buffer depth.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DEPTH  = 2;
  localparam int FETCH_CNT_W  = $clog2(FETCH_DEPTH + 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Shift-style FIFO of fetch entries; slot 0 is always the head, so head
// outputs come straight from a register. Flush beats push and pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [FETCH_CNT_W-1:0] count
);

  fetch_entry_t           slot_reg  [FETCH_DEPTH];
  fetch_entry_t           slot_next [FETCH_DEPTH];
  logic [FETCH_CNT_W-1:0] count_reg, count_next, cnt_after;
  logic                   valid_reg;
  logic                   pop_eff, push_ok;

  assign pop_eff   = pop & (count_reg != '0);
  assign cnt_after = count_reg - FETCH_CNT_W'(pop_eff);
  assign push_ok   = push & (cnt_after < FETCH_CNT_W'(FETCH_DEPTH));

  always_comb begin
    count_next = cnt_after + FETCH_CNT_W'(push_ok);
    if (flush) count_next = '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_DEPTH; gi++) begin : g_slot
      // A popped-to-empty head keeps its old contents so instr/instr_pc hold.
      always_comb begin
        slot_next[gi] = slot_reg[gi];
        if (!flush) begin
          if (gi + 1 < FETCH_DEPTH) begin
            if (pop_eff && (FETCH_CNT_W'(gi + 1) < count_reg))
              slot_next[gi] = slot_reg[(gi + 1) % FETCH_DEPTH];
          end
          if (push_ok && (cnt_after == FETCH_CNT_W'(gi)))
            slot_next[gi] = push_entry;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_reg[gi] <= '0;
        else        slot_reg[gi] <= slot_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      valid_reg <= (count_next != '0);
    end
  end

  assign head       = slot_reg[0];
  assign head_valid = valid_reg;
  assign count      = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: PC register, FETCH/FULL/FAULT state machine, range
// check and branch redirect in front of a 2-entry instruction buffer.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fault
);

  // One extra bit so MEM_DEPTH itself is representable for any ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  fetch_state_t           state_reg, state_next;
  logic [ADDR_W-1:0]      pc_reg, pc_next;
  logic                   fault_reg, fault_next;
  logic                   push, pop, flush, in_range, has_space;
  logic [FETCH_CNT_W-1:0] count;
  fetch_entry_t           push_entry, head;

  assign pop       = instr_valid & instr_ready;
  assign in_range  = {1'b0, pc_reg} < DEPTH_LIM;
  assign has_space = (count < FETCH_CNT_W'(FETCH_DEPTH)) | pop;

  assign push_entry.pc   = FETCH_ADDR_W'(pc_reg);
  assign push_entry.word = mem_data;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    push       = 1'b0;
    flush      = 1'b0;
    if (branch_valid) begin
      flush      = 1'b1;
      pc_next    = branch_target;
      fault_next = 1'b0;
      state_next = FETCH;
    end else begin
      case (state_reg)
        FETCH: begin
          if (!in_range) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end else if (has_space) begin
            push    = 1'b1;
            pc_next = pc_reg + 1'b1;
            if (count == FETCH_CNT_W'(FETCH_DEPTH - 1) && !pop) state_next = FULL;
          end else begin
            state_next = FULL;
          end
        end
        FULL: begin
          // The held PC was incremented after the last push, so it still
          // needs its own range check before being fetched.
          if (pop) begin
            if (in_range) begin
              push       = 1'b1;
              pc_next    = pc_reg + 1'b1;
              state_next = FETCH;
            end else begin
              fault_next = 1'b1;
              state_next = FAULT;
            end
          end
        end
        FAULT:   ;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head       (head),
    .head_valid (instr_valid),
    .count      (count)
  );

  assign mem_addr = pc_reg;
  assign instr    = head.word;
  assign instr_pc = ADDR_W'(head.pc);
  assign fault    = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// ready/branch run scored against an expected-instruction-stream model.
module tb_fetch_sequencer;

  localparam int MEM_DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Model: address of the next instruction decode should receive.
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  assign mem_data = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0BAD_0BAD;

  fetch_sequencer #(.ADDR_W(32), .MEM_DEPTH(MEM_DEPTH), .RESET_PC(32'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fault         (fault)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         exp_pc <= 32'd0;
    else if (branch_valid)              exp_pc <= branch_target;
    else if (instr_valid && instr_ready) exp_pc <= exp_pc + 32'd1;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    branch_valid = 1'b0;
    branch_target = 32'd0;
    instr_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    branch_valid = 1'b0;
    branch_target = 32'd0;
    instr_ready = 1'b0;
    cyc();
    n_checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'd0 || fault !== 1'b0 ||
        instr !== 32'd0 || instr_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b addr=%0d fault=%b instr=%h pc=%0d, required 0 0 0 0 0",
               instr_valid, mem_addr, fault, instr, instr_pc);
    end
    $display("reset: valid=%b addr=%0d fault=%b", instr_valid, mem_addr, fault);
  endtask

  task automatic test_stream();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i) || instr !== mem[i]) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b pc=%0d instr=%h, required 1 %0d %h",
                 i, instr_valid, instr_pc, instr, i, mem[i]);
      end
      $display("stream: pc=%0d instr=%h", instr_pc, instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    n_checks++;
    if (mem_addr !== 32'd2 || instr_valid !== 1'b1 || instr_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL hold: addr=%0d valid=%b pc=%0d, required 2 1 0", mem_addr, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i) || instr !== mem[i]) begin
        n_fail++;
        $display("FAIL drain[%0d]: valid=%b pc=%0d instr=%h, required 1 %0d %h",
                 i, instr_valid, instr_pc, instr, i, mem[i]);
      end
      $display("drain: pc=%0d instr=%h", instr_pc, instr);
    end
    cyc();
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) cyc();
    instr_ready = 1'b1;
    branch_valid = 1'b1;
    branch_target = 32'd6;
    cyc();
    branch_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'd6) begin
      n_fail++;
      $display("FAIL branch_n1: valid=%b addr=%0d, required 0 6", instr_valid, mem_addr);
    end
    for (int i = 6; i < 8; i++) begin
      cyc();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i) || instr !== mem[i]) begin
        n_fail++;
        $display("FAIL branch_stream[%0d]: valid=%b pc=%0d instr=%h, required 1 %0d %h",
                 i, instr_valid, instr_pc, instr, i, mem[i]);
      end
      $display("branch: pc=%0d instr=%h", instr_pc, instr);
    end
  endtask

  task automatic test_fault();
    logic [31:0] want;
    instr_ready = 1'b1;
    branch_valid = 1'b1;
    branch_target = 32'd120;
    cyc();
    branch_valid = 1'b0;
    want = 32'd120;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (instr_valid) begin
        n_checks++;
        if (instr_pc !== want || instr !== mem[want[7:0]] || want >= 32'(MEM_DEPTH)) begin
          n_fail++;
          $display("FAIL fault_stream: pc=%0d instr=%h, required %0d (< %0d) %h",
                   instr_pc, instr, want, MEM_DEPTH, mem[want[7:0]]);
        end
        want = want + 32'd1;
      end
    end
    n_checks++;
    if (want !== 32'd128 || fault !== 1'b1 || mem_addr !== 32'd128 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_end: next=%0d fault=%b addr=%0d valid=%b, required 128 1 128 0",
               want, fault, mem_addr, instr_valid);
    end
    $display("fault: fault=%b addr=%0d", fault, mem_addr);
  endtask

  task automatic test_fault_recover();
    branch_valid = 1'b1;
    branch_target = 32'd3;
    cyc();
    branch_valid = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || mem_addr !== 32'd3 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL recover_n1: fault=%b addr=%0d valid=%b, required 0 3 0", fault, mem_addr, instr_valid);
    end
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd3 || instr !== 32'h8C12_3456) begin
      n_fail++;
      $display("FAIL recover_n2: valid=%b pc=%0d instr=%h, required 1 3 8c123456", instr_valid, instr_pc, instr);
    end
    branch_valid = 1'b1;
    branch_target = 32'd200;
    cyc();
    branch_valid = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || mem_addr !== 32'd200) begin
      n_fail++;
      $display("FAIL far_n1: fault=%b addr=%0d, required 0 200", fault, mem_addr);
    end
    cyc();
    n_checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 32'd200) begin
      n_fail++;
      $display("FAIL far_n2: fault=%b valid=%b addr=%0d, required 1 0 200", fault, instr_valid, mem_addr);
    end
    $display("recover: fault=%b addr=%0d", fault, mem_addr);
  endtask

  task automatic test_random();
    int delivered = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (instr_valid) begin
        n_checks++;
        if (instr_pc !== exp_pc || exp_pc >= 32'(MEM_DEPTH) || instr !== mem[exp_pc[7:0]]) begin
          n_fail++;
          $display("FAIL random: pc=%0d instr=%h, required %0d (< %0d) %h",
                   instr_pc, instr, exp_pc, MEM_DEPTH, mem[exp_pc[7:0]]);
        end
        if (instr_ready) delivered++;
      end
      instr_ready = ($urandom_range(0, 9) < 7);
      branch_valid = ($urandom_range(0, 19) == 0);
      branch_target = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(120, 140))
                                                  : 32'($urandom_range(0, 127));
      cyc();
    end
    branch_valid = 1'b0;
    n_checks++;
    if (delivered < 100) begin
      n_fail++;
      $display("FAIL random_progress: delivered=%0d, required >= 100", delivered);
    end
    $display("random: delivered=%0d", delivered);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b addr=%0d fault=%b, required 0 0 0", instr_valid, mem_addr, fault);
    end
    $display("async_reset: valid=%b addr=%0d", instr_valid, mem_addr);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== mem[0]) begin
      n_fail++;
      $display("FAIL after_reset: valid=%b pc=%0d instr=%h, required 1 0 %h", instr_valid, instr_pc, instr, mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0023_00AA;
    mem[1] = 32'h1065_4321;
    mem[2] = 32'h0010_0022;
    mem[3] = 32'h8C12_3456;
    mem[6] = 32'h1301_2345;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_fault();
    test_fault_recover();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
